mem_io_unit: RTL and testbench

//  Memory/IO stage behind the dual-issue core's M stage. Takes the single M-stage op (load, store, print, scan),

---
 rtl/mem_io_unit.sv | 136 +++++++++++++
 tb/tb_mem_io_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_unit.sv
// mem_io_unit: memory/IO stage behind the M stage; runs one load/store/print/scan op and returns data to W.
// Ports:
//   clk, reset (async, active-high), core_en
//   LwM, MemWriteM, scanM, printM, ALUResultM[31:0], WriteDataM[31:0]  : M-stage op
//   ReadDataW[31:0], wb_valid, stall_m, stall_w, req_ready              : pipeline handshake
//   mem_req_valid/mem_req_ready, mem_we, mem_addr, mem_wdata            : data-memory request
//   mem_rvalid, mem_rdata                                               : data-memory load return
//   tx_valid/tx_ready/tx_data, rx_valid/rx_ready/rx_data                : UART byte streams
// Build option: define MEM_IO_WORD_SCAN_EN to make scan read a little-endian 32-bit word (4 bytes)
// instead of a single zero-extended byte.
module mem_io_unit #(
    parameter int ADDR_W    = 18,
    parameter bit BYTE_ADDR = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_en,
    input  logic              LwM,
    input  logic              MemWriteM,
    input  logic              scanM,
    input  logic              printM,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataW,
    output logic              wb_valid,
    output logic              stall_m,
    output logic              stall_w,
    output logic              req_ready,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [7:0]        rx_data
);
    typedef enum logic [2:0] {IDLE, MREQ, MWAIT, TX, RX, WB} state_t;
    state_t state, nextState;
    logic [ADDR_W-1:0] addrQ, addrIn;
    logic [31:0] wdataQ;
    logic loadQ, accept, accLoad, accStore, accScan, accPrint, rxFire, rxLast, loadReturn;
    logic unusedAddr;

    assign addrIn     = BYTE_ADDR ? ALUResultM[ADDR_W+1:2] : ALUResultM[ADDR_W-1:0];
    assign unusedAddr = ^ALUResultM;
    // Fixed priority among strobes; more than one at once is a core bug caught by the assertion below.
    assign accept   = (state == IDLE) & core_en & (LwM | MemWriteM | scanM | printM);
    assign accLoad  = accept & LwM;
    assign accStore = accept & ~LwM & MemWriteM;
    assign accScan  = accept & ~LwM & ~MemWriteM & scanM;
    assign accPrint = accept & ~LwM & ~MemWriteM & ~scanM & printM;
    assign rxFire   = rx_valid & rx_ready;
    // Load data only counts once the request has been handed off; a stray strobe in IDLE is dropped.
    assign loadReturn = mem_rvalid & (((state == MREQ) & mem_req_ready & loadQ) | (state == MWAIT));

`ifdef MEM_IO_WORD_SCAN_EN
    logic [1:0] byteCnt;
    assign rxLast = byteCnt == 2'd3;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       byteCnt <= 2'd0;
        else if (rxFire) byteCnt <= byteCnt + 2'd1;
    end
`else
    assign rxLast = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = accLoad  ? (mem_req_ready ? MWAIT : MREQ) :
                                 accStore ? (mem_req_ready ? IDLE : MREQ) :
                                 accScan  ? RX :
                                 accPrint ? (tx_ready ? IDLE : TX) : IDLE;
            MREQ:    nextState = !mem_req_ready ? MREQ : !loadQ ? IDLE : mem_rvalid ? WB : MWAIT;
            MWAIT:   nextState = mem_rvalid ? WB : MWAIT;
            TX:      nextState = tx_ready ? IDLE : TX;
            RX:      nextState = (rxFire & rxLast) ? WB : RX;
            WB:      nextState = core_en ? IDLE : WB;
            default: nextState = IDLE;
        endcase
    end

    // The accept cycle drives the request straight from the M-stage inputs so a store/print
    // meeting a ready sink completes without ever leaving IDLE.
    always_comb begin
        mem_req_valid = (state == MREQ) | accLoad | accStore;
        mem_we        = (state == MREQ) ? ~loadQ : accStore;
        mem_addr      = (state == MREQ) ? addrQ : (accLoad | accStore) ? addrIn : '0;
        mem_wdata     = (state == MREQ) ? wdataQ : accStore ? WriteDataM : 32'd0;
        tx_valid      = (state == TX) | accPrint;
        tx_data       = (state == TX) ? wdataQ[7:0] : accPrint ? WriteDataM[7:0] : 8'd0;
        rx_ready      = state == RX;
        wb_valid      = state == WB;
        stall_w       = (state == WB) & ~core_en;
        req_ready     = state == IDLE;
        stall_m       = (state == IDLE) ? accept & ~((accStore & mem_req_ready) | (accPrint & tx_ready))
                                        : state != WB;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addrQ     <= '0;
            wdataQ    <= 32'd0;
            loadQ     <= 1'b0;
            ReadDataW <= 32'd0;
        end else begin
            if (accept) begin
                addrQ  <= addrIn;
                wdataQ <= WriteDataM;
                loadQ  <= LwM;
            end
            if (loadReturn) ReadDataW <= mem_rdata;
`ifdef MEM_IO_WORD_SCAN_EN
            else if (rxFire) ReadDataW[8*byteCnt +: 8] <= rx_data;
`else
            else if (rxFire) ReadDataW <= {24'd0, rx_data};
`endif
        end
    end

`ifndef SYNTHESIS
    strobeOneHot: assert property (@(posedge clk) disable iff (reset)
        ((state == IDLE) && core_en) |-> $onehot0({LwM, MemWriteM, scanM, printM}));
`endif
endmodule

// File: tb/tb_mem_io_unit.sv
// tb_mem_io_unit: directed self-checking bench for mem_io_unit.
module tb_mem_io_unit;
    logic        clk = 1'b0, reset = 1'b1, core_en = 1'b0;
    logic        LwM = 1'b0, MemWriteM = 1'b0, scanM = 1'b0, printM = 1'b0;
    logic [31:0] ALUResultM = 32'd0, WriteDataM = 32'd0;
    logic [31:0] ReadDataW;
    logic        wb_valid, stall_m, stall_w, req_ready;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_we;
    logic [17:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata = 32'd0;
    logic        mem_rvalid = 1'b0;
    logic        tx_valid, tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        rx_valid = 1'b0, rx_ready;
    logic [7:0]  rx_data = 8'd0;
    int errors = 0, checks = 0;
    int stallCnt, wbCnt, fireCnt, holdCnt, idx;
    logic [31:0] scanData;
    logic [7:0] rxBytes [4] = '{8'h78, 8'h56, 8'h34, 8'h12};

    mem_io_unit dut (
        .clk(clk), .reset(reset), .core_en(core_en),
        .LwM(LwM), .MemWriteM(MemWriteM), .scanM(scanM), .printM(printM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataW(ReadDataW), .wb_valid(wb_valid), .stall_m(stall_m), .stall_w(stall_w),
        .req_ready(req_ready), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset values
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_stall_m", stall_m, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_rdata", ReadDataW, 0);
        check("rst_outs", {mem_req_valid, tx_valid, rx_ready, stall_w}, 0);
        // no accept while core_en low
        nextCycle(); reset = 1'b0; LwM = 1'b1; ALUResultM = 32'h40;
        @(negedge clk);
        check("off_noreq", mem_req_valid, 0);
        check("off_nostall", stall_m, 0);
        nextCycle();
        @(negedge clk);
        check("off_idle", req_ready, 1);
        core_en = 1'b1;
        // load 0x40, memory ready, data three cycles after accept
        stallCnt = 0; wbCnt = 0;
        for (int c = 0; c < 6; c++) begin
            nextCycle();
            LwM = (c == 0); ALUResultM = 32'h40; mem_req_ready = 1'b1;
            mem_rvalid = (c == 3); mem_rdata = (c == 3) ? 32'hDEADBEEF : 32'h0;
            @(negedge clk);
            stallCnt += int'(stall_m); wbCnt += int'(wb_valid);
            if (c == 0) begin
                check("ld_addr", mem_addr, 32'h10);
                check("ld_reqv", mem_req_valid, 1);
                check("ld_we", mem_we, 0);
            end
            if (c == 4) check("ld_data", ReadDataW, 32'hDEADBEEF);
            if (c == 5) check("ld_idle", req_ready, 1);
        end
        check("ld_stall_cycles", stallCnt, 4);
        check("ld_wb_cycles", wbCnt, 1);
        // load where handshake and data return share a cycle
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            LwM = (c == 0); ALUResultM = 32'h44; mem_req_ready = (c == 1);
            mem_rvalid = (c == 1); mem_rdata = (c == 1) ? 32'h600DF00D : 32'h0;
            @(negedge clk);
            if (c == 0) check("ld2_addr", mem_addr, 32'h11);
            if (c == 1) check("ld2_stall", stall_m, 1);
            if (c == 2) check("ld2_wb", wb_valid, 1);
            if (c == 2) check("ld2_data", ReadDataW, 32'h600DF00D);
            if (c == 3) check("ld2_idle", {wb_valid, req_ready}, 32'h1);
        end
        // store with memory not ready for two cycles
        stallCnt = 0; wbCnt = 0; fireCnt = 0;
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            MemWriteM = (c <= 2); ALUResultM = 32'h8;
            WriteDataM = (c == 0) ? 32'h12345678 : 32'h0; mem_req_ready = (c == 2);
            @(negedge clk);
            stallCnt += int'(stall_m); wbCnt += int'(wb_valid);
            fireCnt += int'(mem_req_valid & mem_req_ready);
            if (c == 0) check("st_addr", mem_addr, 32'h2);
            if (c <= 2) check("st_we", mem_we, 1);
            if (c <= 2) check("st_wdata", mem_wdata, 32'h12345678);
            if (c == 3) check("st_done", {mem_req_valid, req_ready}, 32'h1);
        end
        check("st_stall_cycles", stallCnt, 3);
        check("st_fires", fireCnt, 1);
        check("st_no_wb", wbCnt, 0);
        // print with tx not ready for one cycle
        stallCnt = 0; fireCnt = 0; holdCnt = 0;
        for (int c = 0; c < 3; c++) begin
            nextCycle();
            printM = (c <= 1); WriteDataM = (c == 0) ? 32'h141 : 32'h0; tx_ready = (c == 1);
            @(negedge clk);
            stallCnt += int'(stall_m);
            fireCnt += int'(tx_valid & tx_ready);
            holdCnt += int'(tx_valid && tx_data == 8'h41);
            if (c == 2) check("pr_done", tx_valid, 0);
        end
        check("pr_hold_cycles", holdCnt, 2);
        check("pr_transfers", fireCnt, 1);
        check("pr_stall_cycles", stallCnt, 2);
        // print into an already-ready sink finishes in the accept cycle
        for (int c = 0; c < 2; c++) begin
            nextCycle();
            printM = (c == 0); WriteDataM = 32'h5A; tx_ready = 1'b1;
            @(negedge clk);
            if (c == 0) check("pr1_stall", stall_m, 0);
            if (c == 0) check("pr1_tx", {tx_valid, tx_data}, 32'h15A);
            if (c == 1) check("pr1_idle", {tx_valid, req_ready}, 32'h1);
        end
        tx_ready = 1'b0;
        // scan with gaps between rx bytes
        idx = 0; wbCnt = 0; scanData = 32'hFFFFFFFF;
        for (int c = 0; c < 16; c++) begin
            nextCycle();
            scanM = (c == 0);
            rx_valid = (c % 2 == 0) && (idx < 4);
            rx_data = (idx < 4) ? rxBytes[idx] : 8'h0;
            @(negedge clk);
            if (c == 0) check("sc_accept", {rx_ready, stall_m}, 32'h1);
            if (rx_valid && rx_ready) idx++;
            if (wb_valid) begin
                wbCnt++;
                scanData = ReadDataW;
            end
        end
        check("sc_wb_cycles", wbCnt, 1);
        check("sc_idle_rx_ready", rx_ready, 0);
`ifdef MEM_IO_WORD_SCAN_EN
        check("sc_data", scanData, 32'h12345678);
        check("sc_consumed", idx, 4);
`else
        check("sc_data", scanData, 32'h00000078);
        check("sc_consumed", idx, 1);
`endif
        rx_valid = 1'b0;
        // load returns while core_en is low
        wbCnt = 0; holdCnt = 0;
        for (int c = 0; c < 7; c++) begin
            nextCycle();
            LwM = (c == 0); ALUResultM = 32'h80; mem_req_ready = 1'b1;
            core_en = !(c >= 1 && c <= 4);
            mem_rvalid = (c == 1); mem_rdata = (c == 1) ? 32'hCAFEF00D : 32'h0;
            @(negedge clk);
            wbCnt += int'(wb_valid); holdCnt += int'(stall_w);
            if (c == 3) check("hold_data", ReadDataW, 32'hCAFEF00D);
            if (c == 3) check("hold_stall_m", stall_m, 0);
            if (c == 5) check("hold_consume", {wb_valid, stall_w}, 32'h2);
            if (c == 6) check("hold_idle", {wb_valid, req_ready}, 32'h1);
        end
        check("hold_wb_cycles", wbCnt, 4);
        check("hold_stall_w_cycles", holdCnt, 3);
        // reset while waiting for load data, data arrives after release
        nextCycle(); LwM = 1'b1; ALUResultM = 32'h100; mem_req_ready = 1'b1;
        nextCycle(); LwM = 1'b0;
        @(negedge clk);
        check("rs_wait", stall_m, 1);
        reset = 1'b1;
        #1;
        check("rs_async_idle", {req_ready, stall_m, mem_req_valid}, 32'h4);
        check("rs_rdata", ReadDataW, 0);
        wbCnt = 0;
        nextCycle(); reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            wbCnt += int'(wb_valid);
            nextCycle();
        end
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("rs_no_wb", wbCnt, 0);
        check("rs_rdata_after", ReadDataW, 0);
        check("rs_idle", req_ready, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
